// File: rtl/doce_tx_arbiter.sv
// Packet-granular round-robin arbiter: transport (s0) and control (s1) frames share one 64-bit MAC Tx stream.
// Zero-cycle pass-through while granted, one arbitration cycle between frames; MAC backpressure goes straight to the granted source.
module doce_tx_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [63:0]      s0_axis_tdata,
  input  logic [7:0]       s0_axis_tkeep,
  input  logic             s0_axis_tlast,
  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic [63:0]      s1_axis_tdata,
  input  logic [7:0]       s1_axis_tkeep,
  input  logic             s1_axis_tlast,
  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  output logic [63:0]      doce_axis_txd_tdata,
  output logic [7:0]       doce_axis_txd_tkeep,
  output logic             doce_axis_txd_tlast,
  output logic             doce_axis_txd_tvalid,
  input  logic             doce_axis_txd_tready,
  input  logic             tx_pause,
  output logic             arb_busy,
  output logic             arb_grant,
  output logic [CNT_W-1:0] s0_frame_cnt,
  output logic [CNT_W-1:0] s1_frame_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic             grant_q;
  logic             grant_d;
  logic [CNT_W-1:0] s0_cnt_q;
  logic [CNT_W-1:0] s1_cnt_q;
  logic             sel_vld;
  logic             sel_last;
  logic             eof_xfer;

  // Contested grant goes to whoever did not win last time; an uncontested one to the sole requester.
  always_comb begin
    grant_d  = (s0_axis_tvalid && s1_axis_tvalid) ? ~grant_q : s1_axis_tvalid;
    sel_vld  = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    sel_last = grant_q ? s1_axis_tlast  : s0_axis_tlast;
    eof_xfer = (state_q == BUSY) && sel_vld && doce_axis_txd_tready && sel_last;
  end

  always_comb begin
    doce_axis_txd_tdata  = 64'd0;
    doce_axis_txd_tkeep  = 8'd0;
    doce_axis_txd_tlast  = 1'b0;
    doce_axis_txd_tvalid = 1'b0;
    s0_axis_tready       = 1'b0;
    s1_axis_tready       = 1'b0;
    if (state_q == BUSY) begin
      doce_axis_txd_tdata  = grant_q ? s1_axis_tdata : s0_axis_tdata;
      doce_axis_txd_tkeep  = grant_q ? s1_axis_tkeep : s0_axis_tkeep;
      doce_axis_txd_tlast  = sel_last;
      doce_axis_txd_tvalid = sel_vld;
      s0_axis_tready       = ~grant_q & doce_axis_txd_tready;
      s1_axis_tready       =  grant_q & doce_axis_txd_tready;
    end
  end

  // Pause is only looked at here in IDLE, so a frame already granted always runs to its tlast.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      s0_cnt_q <= '0;
      s1_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!tx_pause && (s0_axis_tvalid || s1_axis_tvalid)) begin
            grant_q <= grant_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (eof_xfer) begin
            state_q <= IDLE;
            if (grant_q) s1_cnt_q <= s1_cnt_q + CNT_ONE;
            else         s0_cnt_q <= s0_cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_busy     = (state_q == BUSY);
  assign arb_grant    = grant_q;
  assign s0_frame_cnt = s0_cnt_q;
  assign s1_frame_cnt = s1_cnt_q;

endmodule

// File: tb/tb_doce_tx_arbiter.sv
// Randomised bench for doce_tx_arbiter: frame-level reference model feeds a beat scoreboard drained by an output monitor.
module tb_doce_tx_arbiter;

  localparam int CW   = 8;
  localparam int CMOD = 1 << CW;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic          clk;
  logic          aresetn;
  logic [63:0]   s0_axis_tdata, s1_axis_tdata;
  logic [7:0]    s0_axis_tkeep, s1_axis_tkeep;
  logic          s0_axis_tlast, s1_axis_tlast;
  logic          s0_axis_tvalid, s1_axis_tvalid;
  logic          s0_axis_tready, s1_axis_tready;
  logic [63:0]   doce_axis_txd_tdata;
  logic [7:0]    doce_axis_txd_tkeep;
  logic          doce_axis_txd_tlast;
  logic          doce_axis_txd_tvalid;
  logic          doce_axis_txd_tready;
  logic          tx_pause;
  logic          arb_busy;
  logic          arb_grant;
  logic [CW-1:0] s0_frame_cnt, s1_frame_cnt;

  doce_tx_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .aresetn(aresetn),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tlast(s0_axis_tlast),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tlast(s1_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .doce_axis_txd_tdata(doce_axis_txd_tdata), .doce_axis_txd_tkeep(doce_axis_txd_tkeep),
    .doce_axis_txd_tlast(doce_axis_txd_tlast), .doce_axis_txd_tvalid(doce_axis_txd_tvalid),
    .doce_axis_txd_tready(doce_axis_txd_tready),
    .tx_pause(tx_pause), .arb_busy(arb_busy), .arb_grant(arb_grant),
    .s0_frame_cnt(s0_frame_cnt), .s1_frame_cnt(s1_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk = 0, n_pass = 0;
  beat_t dq0[$], dq1[$];        // beats still to be offered by each source
  beat_t mq0[$], mq1[$];        // frames not yet granted, as the model sees them
  beat_t expq[$];               // beats the MAC must see, in order
  logic  glog[$];               // DUT grant at each frame start
  int    acc0 = 0, acc1 = 0;
  int    bub0 = 0, bub1 = 0, rdy_pct = 100, pause_pct = 0;
  bit    force_pause = 0, force_rst = 1;
  bit    chk_en = 0;
  bit    m_busy = 0, m_grant = 1;
  int    m_cnt0 = 0, m_cnt1 = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  task automatic add_frame(input int s, input int len, input logic [7:0] lk);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom(), $urandom()};
      b.k = (i == len - 1) ? lk : 8'hFF;
      b.l = (i == len - 1);
      if (s == 0) begin dq0.push_back(b); mq0.push_back(b); end
      else        begin dq1.push_back(b); mq1.push_back(b); end
    end
  endtask

  // Source/MAC driver: inputs change 1 time unit after the clock edge; valid is held until accepted.
  initial begin
    bit a0, a1, rs;
    aresetn = 1'b0; tx_pause = 1'b0; doce_axis_txd_tready = 1'b0;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0;
    forever begin
      @(negedge clk);
      a0 = s0_axis_tvalid && s0_axis_tready;
      a1 = s1_axis_tvalid && s1_axis_tready;
      rs = !aresetn;
      @(posedge clk);
      #1;
      if (rs) begin
        dq0.delete(); dq1.delete();
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
      end else begin
        if (a0) begin void'(dq0.pop_front()); acc0++; end
        if (a1) begin void'(dq1.pop_front()); acc1++; end
      end
      if (!(s0_axis_tvalid && !a0)) begin
        s0_axis_tvalid = (dq0.size() > 0) && ($urandom_range(99, 0) >= bub0);
        if (s0_axis_tvalid) {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast} = dq0[0];
        else {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast} = {$urandom(), $urandom(), 9'($urandom())};
      end
      if (!(s1_axis_tvalid && !a1)) begin
        s1_axis_tvalid = (dq1.size() > 0) && ($urandom_range(99, 0) >= bub1);
        if (s1_axis_tvalid) {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast} = dq1[0];
        else {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast} = {$urandom(), $urandom(), 9'($urandom())};
      end
      doce_axis_txd_tready = ($urandom_range(99, 0) < rdy_pct);
      tx_pause = force_pause || ($urandom_range(99, 0) < pause_pct);
      aresetn  = !force_rst;
    end
  end

  // Reference model: one frame at a time; grant goes to the lone requester or, if both ask, away from the last winner.
  always @(negedge clk) begin
    bit    g, done, sv, sl;
    beat_t mb;
    if (chk_en) begin
      chk("arb_busy", 80'(arb_busy), 80'(m_busy));
      chk("arb_grant", 80'(arb_grant), 80'(m_grant));
      chk("s0_frame_cnt", 80'(s0_frame_cnt), 80'(m_cnt0 % CMOD));
      chk("s1_frame_cnt", 80'(s1_frame_cnt), 80'(m_cnt1 % CMOD));
      chk("s0_tready", 80'(s0_axis_tready), 80'(m_busy && !m_grant && doce_axis_txd_tready));
      chk("s1_tready", 80'(s1_axis_tready), 80'(m_busy && m_grant && doce_axis_txd_tready));
      chk("m_tvalid", 80'(doce_axis_txd_tvalid),
          80'(m_busy && (m_grant ? s1_axis_tvalid : s0_axis_tvalid)));
    end
    if (!aresetn) begin
      m_busy = 0; m_grant = 1; m_cnt0 = 0; m_cnt1 = 0;
      mq0.delete(); mq1.delete(); expq.delete();
      chk_en = 1;
    end else if (!m_busy) begin
      if (!tx_pause && (s0_axis_tvalid || s1_axis_tvalid)) begin
        g = (s0_axis_tvalid && s1_axis_tvalid) ? !m_grant : s1_axis_tvalid;
        m_grant = g;
        m_busy  = 1;
        done    = 0;
        while (!done) begin
          if ((g ? mq1.size() : mq0.size()) == 0) begin
            fail_to("model_frame_missing");
            done = 1;
          end else begin
            if (g) mb = mq1.pop_front();
            else   mb = mq0.pop_front();
            expq.push_back(mb);
            done = mb.l;
          end
        end
      end
    end else begin
      sv = m_grant ? s1_axis_tvalid : s0_axis_tvalid;
      sl = m_grant ? s1_axis_tlast  : s0_axis_tlast;
      if (sv && doce_axis_txd_tready && sl) begin
        if (m_grant) m_cnt1++;
        else         m_cnt0++;
        m_busy = 0;
      end
    end
  end

  // Output monitor: every MAC transfer must be the next expected beat.
  always @(negedge clk) begin
    beat_t ob;
    if (chk_en && aresetn && doce_axis_txd_tvalid === 1'b1 && doce_axis_txd_tready) begin
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got %0h, expected none",
                 {doce_axis_txd_tdata, doce_axis_txd_tkeep, doce_axis_txd_tlast});
      end else begin
        ob = expq.pop_front();
        chk("mac_beat", 80'({doce_axis_txd_tdata, doce_axis_txd_tkeep, doce_axis_txd_tlast}), 80'(ob));
      end
    end
  end

  always @(negedge clk) begin
    bit prev_busy;
    if (chk_en && arb_busy === 1'b1 && !prev_busy) glog.push_back(arb_grant);
    prev_busy = (arb_busy === 1'b1);
  end

  task automatic wait_drain(input string nm, input int maxc);
    int c = 0;
    while (!(dq0.size() == 0 && dq1.size() == 0 && expq.size() == 0 && !m_busy && arb_busy === 1'b0)
           && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) fail_to(nm);
    @(negedge clk);
  endtask

  task automatic wait_busy(input string nm, input int maxc);
    int c = 0;
    while (arb_busy !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) fail_to(nm);
  endtask

  task automatic wait_acc0(input string nm, input int target, input int maxc);
    int c = 0;
    while (acc0 < target && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) fail_to(nm);
  endtask

  initial begin
    int n, base, s1_before;
    logic [7:0] lk;
    repeat (3) @(posedge clk);
    #2 force_rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 80'(arb_grant), 80'd1);
    chk("rst_busy", 80'(arb_busy), 80'd0);
    chk("rst_m_tvalid", 80'(doce_axis_txd_tvalid), 80'd0);

    // Lone s0 three-beat frame.
    add_frame(0, 3, 8'h0F);
    wait_drain("drain_single", 100);
    chk("single_s0_cnt", 80'(s0_frame_cnt), 80'd1);
    chk("single_grant", 80'(arb_grant), 80'd0);

    // Both sources saturated with two-beat frames: grants alternate starting with s1.
    glog.delete();
    for (int i = 0; i < 4; i++) begin add_frame(0, 2, 8'hFF); add_frame(1, 2, 8'hFF); end
    wait_drain("drain_alt", 200);
    chk("alt_frames", 80'(glog.size()), 80'd8);
    for (int i = 0; i < glog.size() && i < 8; i++) chk("alt_grant", 80'(glog[i]), 80'((i % 2) == 0));
    chk("alt_s0_cnt", 80'(s0_frame_cnt), 80'd5);
    chk("alt_s1_cnt", 80'(s1_frame_cnt), 80'd4);

    // s1 frames under MAC backpressure and source bubbles.
    rdy_pct = 50; bub1 = 40;
    for (int i = 0; i < 3; i++) add_frame(1, 4, 8'h3F);
    wait_drain("drain_bp", 400);
    chk("bp_s1_cnt", 80'(s1_frame_cnt), 80'd7);
    rdy_pct = 100; bub1 = 0;

    // Pause raised mid-frame: frame completes, then nothing is granted until release.
    base = acc0;
    add_frame(0, 4, 8'hFF);
    wait_acc0("pause_beat1", base + 1, 50);
    force_pause = 1;
    add_frame(0, 1, 8'h01);
    add_frame(1, 1, 8'h03);
    wait_acc0("pause_eof", base + 4, 50);
    repeat (4) @(negedge clk);
    chk("pause_busy", 80'(arb_busy), 80'd0);
    chk("pause_s0_cnt", 80'(s0_frame_cnt), 80'd6);
    chk("pause_s1_rdy", 80'(s1_axis_tready), 80'd0);
    force_pause = 0;
    wait_busy("pause_release", 20);
    chk("pause_release_grant", 80'(arb_grant), 80'd1);
    wait_drain("drain_pause", 100);

    // Randomised mix.
    bub0 = 30; bub1 = 30; rdy_pct = 70; pause_pct = 10;
    for (int i = 0; i < 40; i++) begin
      lk = 8'hFF;
      lk = lk >> $urandom_range(7, 0);
      add_frame($urandom_range(1, 0), $urandom_range(5, 1), lk);
    end
    wait_drain("drain_random", 5000);
    bub0 = 0; bub1 = 0; rdy_pct = 100; pause_pct = 0;

    // Counter wrap: bring s0 to its maximum, then one more frame.
    s1_before = m_cnt1 % CMOD;
    n = CMOD - 1 - (m_cnt0 % CMOD);
    for (int i = 0; i < n; i++) add_frame(0, 1, 8'hFF);
    wait_drain("drain_preload", 4 * CMOD);
    chk("wrap_max", 80'(s0_frame_cnt), 80'(CMOD - 1));
    add_frame(0, 1, 8'hFF);
    wait_drain("drain_wrap", 20);
    chk("wrap_zero", 80'(s0_frame_cnt), 80'd0);
    chk("wrap_s1_kept", 80'(s1_frame_cnt), 80'(s1_before));

    // One-cycle reset in the middle of a frame.
    base = acc0;
    add_frame(0, 4, 8'hFF);
    wait_acc0("rst_beat1", base + 1, 50);
    force_rst = 1;
    @(posedge clk);
    #2 force_rst = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_m_tvalid", 80'(doce_axis_txd_tvalid), 80'd0);
    chk("mid_rst_s0_rdy", 80'(s0_axis_tready), 80'd0);
    chk("mid_rst_s1_rdy", 80'(s1_axis_tready), 80'd0);
    chk("mid_rst_busy", 80'(arb_busy), 80'd0);
    chk("mid_rst_s0_cnt", 80'(s0_frame_cnt), 80'd0);
    chk("mid_rst_s1_cnt", 80'(s1_frame_cnt), 80'd0);
    add_frame(0, 2, 8'hFF);
    add_frame(1, 2, 8'hFF);
    wait_busy("post_rst_busy", 20);
    chk("post_rst_grant", 80'(arb_grant), 80'd0);
    wait_drain("drain_post_rst", 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/doce_tx_arbiter.md
Name: doce_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 64-bit DoCE Tx MAC interface between two frame sources.
- Source 0 is transport-layer Tx traffic, taken after the 128-to-64 width converter. Source 1 is a local control-frame path (ARP replies and link-management frames).
- Sits between the transport layer and the Ethernet MAC Tx port.
- Holds the grant for a whole frame, supports a frame-boundary pause, and keeps per-source frame counters.

Parameters:
- CNT_W, 16, width of the per-source sent-frame counters.

Ports:
- clk  in  1  single clock for the block.
- aresetn  in  1  synchronous active-low reset.
- s0_axis_tdata  in  64  source 0 (transport) data.
- s0_axis_tkeep  in  8  source 0 byte enables.
- s0_axis_tlast  in  1  source 0 end of frame.
- s0_axis_tvalid  in  1  source 0 valid.
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata  in  64  source 1 (control) data.
- s1_axis_tkeep  in  8  source 1 byte enables.
- s1_axis_tlast  in  1  source 1 end of frame.
- s1_axis_tvalid  in  1  source 1 valid.
- s1_axis_tready  out  1  source 1 ready.
- doce_axis_txd_tdata  out  64  data to MAC.
- doce_axis_txd_tkeep  out  8  byte enables to MAC.
- doce_axis_txd_tlast  out  1  end of frame to MAC.
- doce_axis_txd_tvalid  out  1  valid to MAC.
- doce_axis_txd_tready  in  1  MAC ready.
- tx_pause  in  1  when high, no new frame is granted.
- arb_busy  out  1  high while a frame is in flight (state BUSY).
- arb_grant  out  1  index of the current or last granted source.
- s0_frame_cnt  out  CNT_W  frames completed from source 0.
- s1_frame_cnt  out  CNT_W  frames completed from source 1.

Behaviour:
- Reset is synchronous: sampled on the clk edge while aresetn=0. Reset values:
  - state IDLE.
  - arb_grant=1, so source 0 wins the first contest.
  - arb_busy=0.
  - Both frame counters 0.
  - Both s*_axis_tready=0 and doce_axis_txd_tvalid=0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - All treadys are 0 and m tvalid is 0.
  - If tx_pause=0 and at least one s*_tvalid=1, register a grant and move to BUSY next cycle.
  - Round-robin rule: if both sources request, grant the source that is not arb_grant. Otherwise grant the only requester.
  - If tx_pause=1, stay in IDLE regardless of valids.
- BUSY (granted source g):
  - Combinational pass-through: m tdata/tkeep/tlast/tvalid = s_g; s_g tready = doce_axis_txd_tready.
  - The non-granted source's tready is 0.
  - Beat transfers when s_g tvalid and m tready are both 1 in the same cycle.
  - On a transfer with tlast=1: increment s_g frame counter, then return to IDLE next cycle.
  - The counter wraps from 2^CNT_W-1 to 0 with no saturation.
- Latency and throughput:
  - 0-cycle data path in BUSY.
  - 1 idle cycle of arbitration between consecutive frames.
  - A single-beat frame occupies 2 cycles minimum.
- Handshake rules:
  - m tvalid follows s_g tvalid. Bubbles from the source mid-frame pass through, and the grant is held.
  - Backpressure (m tready=0) holds s_g tready=0; the source must keep its data stable per AXI-Stream.
  - The arbiter never drops or reorders beats.
- tx_pause:
  - Sampled only in IDLE.
  - Asserting it in BUSY does not truncate the current frame. The pause takes effect after tlast.
- Simultaneous events:
  - tlast transfer and a new request in the same cycle: the new request is evaluated in the following IDLE cycle. Any alternation is decided by the updated arb_grant.
  - A request deasserted in IDLE before grant carries no obligation to the arbiter.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. A partial frame on the MAC is the MAC's responsibility (it sees tvalid drop without tlast); the upstream sources are reset by the same aresetn.
- arb_busy=1 exactly in BUSY. arb_grant changes only on an IDLE→BUSY transition.

Test Plan:
- Reset, then only s0 presents a 3-beat frame (tkeep FF,FF,0F), m tready=1 → arb_busy rises 1 cycle after s0_tvalid. MAC sees the 3 beats unchanged with tlast on beat 3. s0_frame_cnt=1, arb_grant=0.
- Both sources continuously offer 2-beat frames → grants alternate 0,1,0,1. Each frame is followed by exactly 1 IDLE cycle. After 8 frames both counters=4.
- Source 1 mid-frame with m tready toggling 1,0,0,1 and s1_tvalid bubbling → no beat duplicated or lost. s0_tready stays 0 throughout. Grant is held until tlast.
- tx_pause asserted during beat 2 of a 4-beat s0 frame → frame completes. Arbiter then stays IDLE with both valids high. Deasserting pause → s1 granted next.
- Preload via 65535 single-beat s0 frames then send one more → s0_frame_cnt wraps to 0. s1_frame_cnt is unaffected.
- aresetn low for 1 cycle during beat 2 of a frame → next cycle: tvalid=0, treadys=0, arb_busy=0, counters=0. The first post-reset contest with both sources requesting goes to s0.
